// File: rtl/mcdf_pkg.sv
// Shared MCDF definitions: reader FSM states, packet length decode and
// channel id width.
package mcdf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SEND = 2'd2,
    TAIL = 2'd3
  } state_t;

  localparam int MCDF_CHID_W = 2;

  function automatic logic [5:0] len_decode(input logic [1:0] sel);
    logic [5:0] len;
    case (sel)
      2'b00:   len = 6'd4;
      2'b01:   len = 6'd8;
      2'b10:   len = 6'd16;
      default: len = 6'd32;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/mcdf_fmt_reader.sv
// Read-side packetiser for one MCDF slave channel: waits for a full packet in
// the FIFO, requests the formatter bus, then pops and frames one packet.
module mcdf_fmt_reader
  import mcdf_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 64,
  parameter int CH_ID      = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            pkt_len_sel_i,
  input  logic                  fifo_empty_i,
  input  logic [5:0]            fifo_margin_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic                  fifo_rd_en_o,
  output logic                  fmt_req_o,
  input  logic                  fmt_grant_i,
  output logic                  fmt_send_o,
  output logic                  fmt_start_o,
  output logic                  fmt_end_o,
  output logic [DATA_WIDTH-1:0] fmt_data_o,
  output logic [1:0]            fmt_chid_o,
  output logic [5:0]            fmt_length_o,
  output logic [1:0]            dbg_state_o
);

  // Bus handshake: fmt_req_o stays high in REQ until a one-cycle fmt_grant_i
  // pulse is seen there; grant in any other state is ignored. Each word is
  // valid only in a cycle where fmt_send_o=1; there is no downstream stall.

  state_t     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [5:0] len_q, len_d;
  logic       send_q, send_d;
  logic       start_q, start_d;
  logic       end_q, end_d;
  logic [6:0] occ;
  logic       rd_en;
  logic       req;

  // Empty FIFO reports margin 63, so the empty flag must override the math.
  assign occ = fifo_empty_i ? 7'd0 : (7'(FIFO_DEPTH) - {1'b0, fifo_margin_i});

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    rd_en   = 1'b0;
    req     = 1'b0;
    start_d = 1'b0;
    end_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (occ >= {1'b0, len_decode(pkt_len_sel_i)}) begin
          len_d   = len_decode(pkt_len_sel_i);
          state_d = REQ;
        end
      end
      REQ: begin
        req = 1'b1;
        if (fmt_grant_i) begin
          cnt_d   = len_q;
          state_d = SEND;
        end
      end
      SEND: begin
        rd_en = ~fifo_empty_i;
        if (rd_en) begin
          start_d = (cnt_q == len_q);
          end_d   = (cnt_q == 6'd1);
          cnt_d   = cnt_q - 6'd1;
          if (cnt_q == 6'd1) state_d = TAIL;
        end
      end
      TAIL: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    send_d = rd_en;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      send_q  <= 1'b0;
      start_q <= 1'b0;
      end_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      send_q  <= send_d;
      start_q <= start_d;
      end_q   <= end_d;
    end
  end

  // FIFO read data is registered, so it lines up with the delayed send flag.
  assign fifo_rd_en_o = rd_en;
  assign fmt_req_o    = req;
  assign fmt_send_o   = send_q;
  assign fmt_start_o  = start_q;
  assign fmt_end_o    = end_q;
  assign fmt_data_o   = send_q ? fifo_data_i : '0;
  assign fmt_chid_o   = MCDF_CHID_W'(CH_ID);
  assign fmt_length_o = len_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_mcdf_fmt_reader.sv
// Bench for mcdf_fmt_reader: behavioural FIFO, directed scenarios plus
// randomized packets, scoreboard of written words and expected packet lengths.
module tb_mcdf_fmt_reader;
  import mcdf_pkg::*;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    sel = 2'b00;
  logic          fifo_empty;
  logic [5:0]    fifo_margin;
  logic [DW-1:0] fifo_data = '0;
  logic          rd_en;
  logic          req;
  logic          grant = 1'b0;
  logic          send;
  logic          start;
  logic          endm;
  logic [DW-1:0] data;
  logic [1:0]    chid;
  logic [5:0]    length;
  logic [1:0]    dbg_state;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  mcdf_fmt_reader #(.DATA_WIDTH(DW), .FIFO_DEPTH(64), .CH_ID(0)) dut (
    .clk          (clk),
    .rst          (rst),
    .pkt_len_sel_i(sel),
    .fifo_empty_i (fifo_empty),
    .fifo_margin_i(fifo_margin),
    .fifo_data_i  (fifo_data),
    .fifo_rd_en_o (rd_en),
    .fmt_req_o    (req),
    .fmt_grant_i  (grant),
    .fmt_send_o   (send),
    .fmt_start_o  (start),
    .fmt_end_o    (endm),
    .fmt_data_o   (data),
    .fmt_chid_o   (chid),
    .fmt_length_o (length),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- behavioural 64-deep FIFO ----------------
  logic [DW-1:0] mem [64];
  int            wp = 0, rp = 0, cnt = 0, pop_cnt = 0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;

  always @(posedge clk) begin
    if (rd_en && cnt > 0) begin
      fifo_data <= mem[rp];
      rp = (rp + 1) % 64;
      cnt--;
      pop_cnt++;
    end
    if (wr_en && cnt < 64) begin
      mem[wp] = wr_data;
      wp = (wp + 1) % 64;
      cnt++;
    end
  end

  assign fifo_empty  = (cnt == 0);
  assign fifo_margin = (cnt == 0) ? 6'd63 : 6'(64 - cnt);

  // ---------------- checking ----------------
  int n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  logic [5:0]    exp_len_q[$];
  int            idx = 0, chk_cnt = 0, cur_len = 0;
  bit            mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (fifo_empty) check("rd_while_empty", rd_en, 0);
      if (dbg_state != SEND) check("rd_outside_send", rd_en, 0);
      check("chid", chid, 0);
      if (send) begin
        if (exp_len_q.size() == 0 || exp_q.size() == 0) begin
          check("unexpected_send", send, 0);
        end else begin
          cur_len = exp_len_q[0];
          check("data", data, exp_q.pop_front());
          check("start", start, idx == 0);
          check("end", endm, idx == cur_len - 1);
          check("length", length, cur_len);
          chk_cnt++;
          idx++;
          if (idx == cur_len) begin
            idx = 0;
            void'(exp_len_q.pop_front());
          end
        end
      end else begin
        check("idle_outputs", {start, endm, data}, 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_words(input int n);
    for (int i = 0; i < n; i++) begin
      wr_data = $urandom;
      wr_en   = 1'b1;
      exp_q.push_back(wr_data);
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic wait_req();
    int k = 0;
    while (!req && k < 200) begin
      tick();
      k++;
    end
    check("req_timeout", req, 1);
  endtask

  // Grants in the current cycle (G) and checks the read/send windows through G+L+2.
  task automatic run_packet(input int len, input int mid_sel);
    check("req_before_grant", req, 1);
    grant = 1'b1;
    tick();
    grant = 1'b0;
    check("req_after_grant", req, 0);
    for (int i = 1; i <= len; i++) begin
      check("rd_window", rd_en, 1);
      check("send_window", send, i >= 2);
      if (i == 2 && mid_sel >= 0) sel = mid_sel[1:0];
      tick();
    end
    check("rd_after", rd_en, 0);
    check("send_tail", send, 1);
    check("end_tail", endm, 1);
    check("state_tail", dbg_state, TAIL);
    tick();
    check("send_done", send, 0);
    check("state_idle_after", dbg_state, IDLE);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int occ_m;
    int lost;

    // Reset held for 3 cycles with grant driven high.
    for (int i = 0; i < 3; i++) begin
      grant = 1'b1;
      tick();
      check("rst_req", req, 0);
      check("rst_rd", rd_en, 0);
      check("rst_send", send, 0);
      check("rst_start_end", {start, endm}, 0);
      check("rst_data", data, 0);
      check("rst_length", length, 0);
      check("rst_state", dbg_state, IDLE);
    end
    grant  = 1'b0;
    rst    = 1'b0;
    mon_en = 1'b1;

    // Grant pulse in IDLE is ignored.
    grant = 1'b1;
    tick();
    grant = 1'b0;
    check("idle_grant_state", dbg_state, IDLE);
    check("idle_grant_req", req, 0);
    check("idle_grant_rd", rd_en, 0);
    tick();
    check("idle_grant_state2", dbg_state, IDLE);

    // Threshold: 3 words no request, 4th word triggers.
    sel = 2'b00;
    exp_len_q.push_back(6'd4);
    write_words(3);
    repeat (3) begin
      tick();
      check("req_below_thresh", req, 0);
    end
    write_words(1);
    check("req_in_check_cycle", req, 0);
    check("state_in_check_cycle", dbg_state, IDLE);
    tick();
    check("req_rise", req, 1);
    check("len_latched_4", length, 4);
    run_packet(4, -1);

    // Late grant: request held, no reads for 20 cycles.
    exp_len_q.push_back(6'd4);
    write_words(4);
    wait_req();
    repeat (20) begin
      check("late_req_held", req, 1);
      check("late_no_read", rd_en, 0);
      tick();
    end
    run_packet(4, -1);

    // Full FIFO: two back-to-back 32-word packets.
    sel = 2'b11;
    exp_len_q.push_back(6'd32);
    exp_len_q.push_back(6'd32);
    write_words(64);
    check("full_margin", fifo_margin, 0);
    wait_req();
    check("len_latched_32", length, 32);
    run_packet(32, -1);
    wait_req();
    run_packet(32, -1);
    repeat (5) begin
      tick();
      check("drained_no_req", req, 0);
    end
    check("drained_empty", fifo_empty, 1);

    // Select changed mid-packet: current packet keeps 8, next is 4.
    sel = 2'b01;
    exp_len_q.push_back(6'd8);
    exp_len_q.push_back(6'd4);
    write_words(8);
    wait_req();
    check("len_latched_8", length, 8);
    run_packet(8, 0);
    write_words(4);
    wait_req();
    check("len_after_sel_change", length, 4);
    run_packet(4, -1);

    // Reset after 2 of 8 reads.
    sel = 2'b01;
    exp_len_q.push_back(6'd8);
    write_words(8);
    wait_req();
    grant = 1'b1;
    tick();
    grant = 1'b0;
    check("abort_rd1", rd_en, 1);
    tick();
    check("abort_rd2", rd_en, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_rd", rd_en, 0);
    check("abort_req", req, 0);
    check("abort_send", send, 0);
    check("abort_end", endm, 0);
    check("abort_start", start, 0);
    check("abort_data", data, 0);
    check("abort_length", length, 0);
    check("abort_state", dbg_state, IDLE);
    lost = pop_cnt - chk_cnt;
    repeat (lost) void'(exp_q.pop_front());
    idx = 0;
    void'(exp_len_q.pop_front());
    // Six words remain in the FIFO.
    sel = 2'b00;
    exp_len_q.push_back(6'd4);
    wait_req();
    run_packet(4, -1);
    exp_len_q.push_back(6'd4);
    write_words(2);
    wait_req();
    run_packet(4, -1);

    // Randomized packets with random lengths, leftovers and grant delays.
    occ_m = 0;
    for (int p = 0; p < 10; p++) begin
      int s, len, n;
      s   = $urandom_range(0, 3);
      len = 4 << s;
      sel = s[1:0];
      n   = ((len > occ_m) ? (len - occ_m) : 0) + $urandom_range(0, 3);
      if (occ_m + n > 64) n = 64 - occ_m;
      exp_len_q.push_back(6'(len));
      write_words(n);
      occ_m += n;
      wait_req();
      check("rand_len_latched", length, len);
      repeat ($urandom_range(0, 4)) begin
        check("rand_req_held", req, 1);
        tick();
      end
      run_packet(len, -1);
      occ_m -= len;
    end

    repeat (3) tick();
    check("sb_words_left", exp_q.size(), occ_m);
    check("sb_packets_left", exp_len_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
